// File: rtl/mem_access.sv
// mem_access: load/store stage with IDLE/REQ/WB FSM, lane steering, error detection and ack timeout
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready                 ALU-stage handshake
//   ALU_out, d_add, d_r_en, d_w_en    result/store data, byte address, load/store enables
//   f3, alu_rd, alu_reg_w_en          funct3 width/sign code, destination, reg write request
//   mem_req/we/addr/wdata/wstrb       data-memory request, held until mem_ack
//   mem_ack, mem_rdata                memory completion and read word
//   wb_valid, wb_en, wb_rd, wb_data   one-cycle writeback pulse
//   err                               one-cycle pulse on misalign/illegal f3/conflict/timeout
module mem_access #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALU_out,
  input  logic [31:0] d_add,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [2:0]  f3,
  input  logic [4:0]  alu_rd,
  input  logic        alu_reg_w_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic        w_mem, w_f3_ok, w_mis, w_bad, w_alu_en, w_ld_en;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_sh, w_ld;
  assign in_ready = (r_state == IDLE);
  always_comb begin
    w_mem    = d_r_en | d_w_en;
    w_f3_ok  = d_r_en ? (f3 != 3'b011 && f3[2:1] != 2'b11) : (f3[2:1] != 2'b11 && f3 < 3'd3);
    w_mis    = (f3[1:0] == 2'b01 && d_add[0]) || (f3[1:0] == 2'b10 && d_add[1:0] != 2'b00);
    w_bad    = (d_r_en && d_w_en) || (w_mem && (!w_f3_ok || w_mis));
    w_alu_en = alu_reg_w_en && alu_rd != 5'd0;
    w_strb   = f3[1:0] == 2'b00 ? 4'b0001 << d_add[1:0] :
               f3[1:0] == 2'b01 ? 4'b0011 << d_add[1:0] : 4'b1111;
    w_wdata  = f3[1:0] == 2'b00 ? {4{ALU_out[7:0]}} :
               f3[1:0] == 2'b01 ? {2{ALU_out[15:0]}} : ALU_out;
    // shift the addressed lane down to bit 0; half lanes are 0 or 2 once alignment is checked
    w_sh     = mem_rdata >> {r_lane, 3'b000};
    w_ld     = r_f3 == 3'b000 ? {{24{w_sh[7]}}, w_sh[7:0]} :
               r_f3 == 3'b001 ? {{16{w_sh[15]}}, w_sh[15:0]} :
               r_f3 == 3'b100 ? {24'd0, w_sh[7:0]} :
               r_f3 == 3'b101 ? {16'd0, w_sh[15:0]} : mem_rdata;
    w_ld_en  = !mem_we && wb_rd != 5'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_lane    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          wb_rd  <= alu_rd;
          r_f3   <= f3;
          r_lane <= d_add[1:0];
          r_cnt  <= '0;
          if (w_bad) begin
            r_state  <= WB;
            wb_valid <= 1'b1;
            err      <= 1'b1;
          end else if (w_mem) begin
            r_state   <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= d_w_en;
            mem_addr  <= {d_add[31:2], 2'b00};
            mem_wstrb <= d_w_en ? w_strb : 4'b0000;
            mem_wdata <= d_w_en ? w_wdata : 32'd0;
          end else begin
            r_state  <= WB;
            wb_valid <= 1'b1;
            wb_en    <= w_alu_en;
            wb_data  <= w_alu_en ? ALU_out : 32'd0;
          end
        end
        REQ: if (mem_ack) begin
          r_state  <= WB;
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          wb_en    <= w_ld_en;
          wb_data  <= w_ld_en ? w_ld : 32'd0;
        end else if (r_cnt == 8'(MEM_TIMEOUT - 1)) begin
          r_state  <= WB;
          mem_req  <= 1'b0;
          wb_valid <= 1'b1;
          err      <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        WB: begin
          r_state  <= IDLE;
          wb_valid <= 1'b0;
          wb_en    <= 1'b0;
          wb_data  <= '0;
          err      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed-vector bench for mem_access
module tb_mem_access;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] ALU_out = '0, d_add = '0;
  logic        d_r_en = 1'b0, d_w_en = 1'b0;
  logic [2:0]  f3 = '0;
  logic [4:0]  alu_rd = '0;
  logic        alu_reg_w_en = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid, wb_en, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  mem_access #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_out(ALU_out), .d_add(d_add), .d_r_en(d_r_en), .d_w_en(d_w_en), .f3(f3),
    .alu_rd(alu_rd), .alu_reg_w_en(alu_reg_w_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    @(negedge clk);
    d_r_en = r; d_w_en = w; f3 = f; d_add = a; ALU_out = alu; alu_rd = rd; alu_reg_w_en = rw;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic mem_op(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] alu, input logic [4:0] rd, input int lat,
                        input logic [31:0] rdata, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic e_en, input logic [31:0] e_data);
    issue(!w, w, f, a, alu, rd, 1'b1);
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, w);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_ready"}, in_ready, 0);
    if (w) begin
      chk({tag, "_strb"}, mem_wstrb, e_strb);
      chk({tag, "_wdata"}, mem_wdata, e_wdata);
    end
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {mem_req, mem_addr[30:0]}, {1'b1, a[30:2], 2'b00});
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, mem_req, 0);
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wben"}, wb_en, e_en);
    chk({tag, "_wbrd"}, wb_rd, rd);
    chk({tag, "_wbdata"}, wb_data, e_data);
    chk({tag, "_err"}, err, 0);
    @(negedge clk);
    chk({tag, "_wbv_end"}, wb_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask
  task automatic err_op(input string tag, input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] a);
    issue(r, w, f, a, 32'h1234_5678, 5'd9, 1'b1);
    chk({tag, "_noreq"}, mem_req, 0);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wben"}, wb_en, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    @(negedge clk);
    chk({tag, "_err_end"}, err, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask
  initial begin
    int  n;
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    issue(0, 0, 3'b000, 32'h0, 32'h0000_0005, 5'd3, 1'b1);
    chk("alu_wbv", wb_valid, 1);
    chk("alu_wben", wb_en, 1);
    chk("alu_wbrd", wb_rd, 3);
    chk("alu_wbdata", wb_data, 32'h5);
    chk("alu_busy", in_ready, 0);
    @(negedge clk);
    chk("alu_wbv_end", wb_valid, 0);
    chk("alu_idle", in_ready, 1);
    issue(0, 0, 3'b000, 32'h0, 32'h0000_0077, 5'd0, 1'b1);
    chk("alu_x0_wben", wb_en, 0);
    chk("alu_x0_wbdata", wb_data, 0);
    @(negedge clk);
    mem_op("lb",  0, 3'b000, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'hFFFF_FF80);
    mem_op("lbu", 0, 3'b100, 32'h103, 32'h0, 5'd7, 3, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'h0000_0080);
    mem_op("lh",  0, 3'b001, 32'h102, 32'h0, 5'd8, 1, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'hFFFF_80FF);
    mem_op("lhu", 0, 3'b101, 32'h100, 32'h0, 5'd8, 2, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'h0000_1234);
    mem_op("lw",  0, 3'b010, 32'h100, 32'h0, 5'd31, 1, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'h80FF_1234);
    mem_op("lb1", 0, 3'b000, 32'h101, 32'h0, 5'd4, 1, 32'h80FF_1234, 4'h0, 32'h0, 1, 32'h0000_0012);
    mem_op("lw_x0", 0, 3'b010, 32'h100, 32'h0, 5'd0, 1, 32'hDEAD_BEEF, 4'h0, 32'h0, 0, 32'h0);
    mem_op("sh",  1, 3'b001, 32'h22, 32'hAAAA_BEEF, 5'd5, 2, 32'h0, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
    mem_op("sb",  1, 3'b000, 32'h21, 32'h1234_565A, 5'd5, 1, 32'h0, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0);
    mem_op("sw",  1, 3'b010, 32'h40, 32'hCAFE_F00D, 5'd5, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
    err_op("lw_mis", 1, 0, 3'b010, 32'h41);
    err_op("f3_011", 1, 0, 3'b011, 32'h40);
    err_op("lh_mis", 1, 0, 3'b001, 32'h101);
    err_op("both_en", 1, 1, 3'b010, 32'h40);
    err_op("st_f3", 0, 1, 3'b100, 32'h40);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_wbv", wb_valid, 0);
    chk("stray_ack_ready", in_ready, 1);
    issue(1, 0, 3'b010, 32'h80, 32'h0, 5'd6, 1'b1);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 16);
    chk("to_err", err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_wben", wb_en, 0);
    @(negedge clk);
    chk("to_ready", in_ready, 1);
    chk("to_err_end", err, 0);
    issue(1, 0, 3'b010, 32'h80, 32'h0, 5'd6, 1'b1);
    chk("rmid_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rmid_req_drop", mem_req, 0);
    chk("rmid_ready", in_ready, 1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= wb_valid;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen |= wb_valid;
    end
    chk("rmid_no_wbv", seen, 0);
    issue(0, 0, 3'b000, 32'h0, 32'h0000_00A5, 5'd12, 1'b1);
    chk("post_rst_wbv", wb_valid, 1);
    chk("post_rst_wbrd", wb_rd, 12);
    chk("post_rst_wbdata", wb_data, 32'hA5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for mem_ack before aborting (legal 2..255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  ALU-stage result valid this cycle.
REQ-005 in_ready  out  1  stage can accept a new ALU result.
REQ-006 ALU_out  in  32  ALU result, or store data for stores.
REQ-007 d_add  in  32  data byte address.
REQ-008 d_r_en / d_w_en  in  1 each  load / store request.
REQ-009 f3  in  3  width/sign code (RV32I funct3).
REQ-010 alu_rd  in  5  destination register; alu_reg_w_en  in  1  register write request.
REQ-011 mem_req  out  1  data-memory request, held until mem_ack.
REQ-012 mem_we  out  1  1 = write.
REQ-013 mem_addr  out  32  word address {d_add[31:2],2'b00}.
REQ-014 mem_wdata  out  32  lane-replicated store data; mem_wstrb  out  4  byte enables.
REQ-015 mem_ack  in  1  memory completion; mem_rdata  in  32  read word, valid with mem_ack.
REQ-016 wb_valid  out  1  one-cycle pulse, instruction retired from this stage.
REQ-017 wb_en  out  1  register-file write enable; wb_rd  out  5; wb_data  out  32.
REQ-018 err  out  1  one-cycle pulse: misaligned, illegal f3, conflicting enables, or timeout.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WB; in_ready SHALL be 1 only in IDLE.
REQ-020 The stage SHALL accept a request when in_valid and in_ready are both 1; all inputs SHALL be captured on acceptance and stay stable internally.
REQ-021 Non-memory ops (d_r_en=d_w_en=0) SHALL go IDLE->WB, wb_data=ALU_out, wb_en=alu_reg_w_en and (alu_rd!=0), latency 1 cycle.
REQ-022 Legal memory ops SHALL go IDLE->REQ; mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be driven from the cycle after acceptance and held constant until mem_ack.
REQ-023 On mem_ack in REQ the stage SHALL capture mem_rdata, drop mem_req next cycle, and go to WB; minimum load/store latency is 2 cycles from acceptance to wb_valid.
REQ-024 WB SHALL assert wb_valid for exactly one cycle and then return to IDLE; there is no downstream backpressure.
REQ-025 Loads: f3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; lane selected by d_add[1:0]; sign- or zero-extend to 32 bits; wb_en=(alu_rd!=0).
REQ-026 Stores: f3 000 sb (wstrb 0001<<a[1:0], byte ALU_out[7:0] replicated x4), 001 sh (0011<<a[1:0], half replicated x2), 010 sw (1111); wb_en=0.
REQ-027 Misaligned accesses (half with a[0]=1, word with a[1:0]!=0), illegal f3, or d_r_en=d_w_en=1 SHALL issue no mem_req and SHALL go directly to WB with wb_en=0 and err=1 in that WB cycle.
REQ-028 A cycle counter SHALL clear on entry to REQ; if MEM_TIMEOUT cycles elapse without mem_ack, the stage SHALL drop mem_req, go to WB with wb_en=0, and pulse err.
REQ-029 mem_ack while not in REQ SHALL be ignored.
REQ-030 wb_rd SHALL equal the captured alu_rd in WB; wb_data SHALL be 0 when wb_en=0.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE; in_ready SHALL be 1; all other outputs and the counter SHALL be 0.
REQ-032 Reset asserted mid-REQ SHALL drop mem_req immediately (asynchronously); the pending instruction SHALL be discarded with no wb_valid.

Verification
REQ-033 ALU op: ALU_out=0x00000005, alu_rd=3, reg_w_en=1 -> next cycle wb_valid=1, wb_en=1, wb_rd=3, wb_data=5.
REQ-034 lb at d_add=0x103, ack after 3 cycles with rdata=0x80FF1234 -> mem_addr=0x100, mem_we=0, wb_data=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-035 sh at d_add=0x22, ALU_out=0xAAAABEEF -> mem_wstrb=1100, mem_wdata=0xBEEFBEEF, mem_we=1, wb_en=0, err=0.
REQ-036 lw at d_add=0x41 -> no mem_req, err pulse, wb_valid=1, wb_en=0; same result for f3=011 with d_r_en=1.
REQ-037 Load with mem_ack never asserted, MEM_TIMEOUT=16 -> mem_req high for exactly 16 cycles, then err and wb_valid pulse, wb_en=0, in_ready=1 the following cycle.
REQ-038 rst_n pulled low during REQ -> mem_req=0 the same cycle, no wb_valid; after release, the next accepted ALU op completes normally.
